// File: rtl/hs32_exec_mem.sv
// hs32 execute-stage memory access engine: address generation, lane steering,
// load extension, misalignment/illegal checks and bus timeout over req/ack.
module hs32_exec_mem #(
    parameter int unsigned   AW    = 32,
    parameter int unsigned   DW    = 32,
    parameter int unsigned   TMO   = 15,
    parameter logic [AW-1:0] VBASE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            accept,
    input  logic [1:0]      op,
    input  logic [1:0]      size,
    input  logic            sext,
    input  logic [AW-1:0]   base,
    input  logic [15:0]     offset,
    input  logic [DW-1:0]   wdata,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   rdata,
    output logic            fault,
    output logic [1:0]      fcode,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   dtw,
    output logic [DW/8-1:0] bmask,
    output logic            rw,
    output logic            reqm,
    input  logic            ackm,
    input  logic [DW-1:0]   dtr,
    input  logic            intrq,
    input  logic [AW-1:0]   addi
);
    localparam int unsigned LANES = DW / 8;
    localparam int unsigned LB    = $clog2(LANES);
    localparam int unsigned W16   = 15;
    localparam int unsigned W32   = (DW >= 32) ? 31 : DW - 1;

    typedef enum logic [1:0] {IDLE, BUS, FIN} state_t;

    state_t        state, state_n;
    logic [AW-1:0] ea, ea_n, ea_calc;
    logic          st, st_n, sx, sx_n;
    logic [1:0]    sz, sz_n, esz, fc_n;
    logic [DW-1:0] wd, wd_n, rd_n;
    logic [7:0]    cnt, cnt_n;
    logic [LB-1:0] lane;
    logic [DW-1:0] shr, ext;
    logic [LANES-1:0] bm;
    logic [2:0]    amask;
    logic          illegal, misal, sbit;
    int unsigned   nbits, nbytes, lanei;

    // Effective address, access checks and lane steering for the latched access
    always_comb begin
        ea_calc = base + AW'($signed(offset));
        esz     = (op == 2'b10) ? 2'b10 : size;
        illegal = (op == 2'b11) || (esz == 2'b11 && DW != 64) || (esz == 2'b10 && DW < 32);
        amask   = 3'((4'd1 << esz) - 4'd1);
        misal   = (ea_calc[2:0] & amask) != 3'b000;

        lane   = ea[LB-1:0];
        lanei  = 32'(lane);
        nbytes = 32'd1 << sz;
        nbits  = nbytes * 8;
        shr    = dtr >> {lane, 3'b000};
        unique case (sz)
            2'b00:   sbit = shr[7];
            2'b01:   sbit = shr[W16];
            2'b10:   sbit = shr[W32];
            default: sbit = shr[DW-1];
        endcase
        ext = '0;
        for (int unsigned i = 0; i < DW; i++)
            ext[i] = (i < nbits) ? shr[i] : (sx & sbit);
        bm = '0;
        for (int unsigned i = 0; i < LANES; i++)
            bm[i] = (i >= lanei) && (i < lanei + nbytes);
    end

    always_comb begin
        state_n = state;
        ea_n    = ea;
        st_n    = st;
        sz_n    = sz;
        sx_n    = sx;
        wd_n    = wd;
        cnt_n   = cnt;
        fc_n    = fcode;
        rd_n    = rdata;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                // A pending interrupt wins over start; start stays pending
                if (intrq) begin
                    ea_n    = VBASE + addi;
                    st_n    = 1'b0;
                    sz_n    = 2'b10;
                    sx_n    = 1'b0;
                    fc_n    = 2'b00;
                    state_n = BUS;
                end else if (start) begin
                    ea_n = ea_calc;
                    st_n = (op == 2'b01);
                    sz_n = esz;
                    sx_n = sext;
                    wd_n = wdata;
                    if (illegal) begin
                        fc_n    = 2'b11;
                        state_n = FIN;
                    end else if (misal) begin
                        fc_n    = 2'b01;
                        state_n = FIN;
                    end else begin
                        fc_n    = 2'b00;
                        state_n = BUS;
                    end
                end
            end
            BUS: begin
                if (ackm) begin
                    if (!st) rd_n = ext;
                    state_n = FIN;
                end else if (cnt + 8'd1 == 8'(TMO)) begin
                    fc_n    = 2'b10;
                    state_n = FIN;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ea    <= '0;
            st    <= 1'b0;
            sz    <= 2'b00;
            sx    <= 1'b0;
            wd    <= '0;
            cnt   <= '0;
            fcode <= 2'b00;
            rdata <= '0;
        end else begin
            state <= state_n;
            ea    <= ea_n;
            st    <= st_n;
            sz    <= sz_n;
            sx    <= sx_n;
            wd    <= wd_n;
            cnt   <= cnt_n;
            fcode <= fc_n;
            rdata <= rd_n;
        end
    end

    always_comb begin
        accept = (state == IDLE) & start & ~intrq;
        busy   = (state != IDLE);
        done   = (state == FIN);
        fault  = done & (fcode != 2'b00);
        reqm   = (state == BUS);
        rw     = reqm & st;
        addr   = reqm ? {ea[AW-1:LB], {LB{1'b0}}} : '0;
        bmask  = reqm ? bm : '0;
        dtw    = rw ? (wd << {lane, 3'b000}) : '0;
    end
endmodule

// File: tb/tb_hs32_exec_mem.sv
// Self-checking bench for hs32_exec_mem: vector table with a result scoreboard
// plus hand-written interrupt and mid-operation reset sequences.
module tb_hs32_exec_mem;
    logic        clk = 0, reset = 1, start = 0, sext = 0, ackm = 0, intrq = 0;
    logic [1:0]  op = 0, size = 0;
    logic [31:0] base = 0, wdata = 0, dtr = 0, addi = 0;
    logic [15:0] offset = 0;
    logic        accept, busy, done, fault, rw, reqm;
    logic [1:0]  fcode;
    logic [31:0] rdata, addr, dtw;
    logic [3:0]  bmask;

    int npass = 0, ntot = 0;

    hs32_exec_mem #(.AW(32), .DW(32), .TMO(15), .VBASE(32'h0000_0100)) dut (
        .clk(clk), .reset(reset), .start(start), .accept(accept), .op(op), .size(size),
        .sext(sext), .base(base), .offset(offset), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .fault(fault), .fcode(fcode), .addr(addr), .dtw(dtw), .bmask(bmask),
        .rw(rw), .reqm(reqm), .ackm(ackm), .dtr(dtr), .intrq(intrq), .addi(addi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op, size;
        logic        sext;
        logic [31:0] base;
        logic [15:0] offset;
        logic [31:0] wdata, dtr;
        int          ackdel;
        logic [31:0] eaddr;
        logic [3:0]  ebm;
        logic [31:0] edtw, erd;
        logic        chkrd;
        logic [1:0]  efc;
        int          ereq;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        chkrd;
        logic [1:0]  fc;
    } res_t;

    res_t sbq[$];
    vec_t vt[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            npass++;
    endtask

    function automatic vec_t mk(input logic [1:0] o, input logic [1:0] s, input logic sx,
                                input logic [31:0] b, input logic [15:0] off,
                                input logic [31:0] wd, input logic [31:0] rdin, input int ad,
                                input logic [31:0] ea, input logic [3:0] bm,
                                input logic [31:0] edw, input logic [31:0] erd,
                                input logic crd, input logic [1:0] fc, input int nreq);
        vec_t v;
        v.op = o; v.size = s; v.sext = sx; v.base = b; v.offset = off; v.wdata = wd;
        v.dtr = rdin; v.ackdel = ad; v.eaddr = ea; v.ebm = bm; v.edtw = edw; v.erd = erd;
        v.chkrd = crd; v.efc = fc; v.ereq = nreq;
        return v;
    endfunction

    task automatic run(input int idx, input vec_t v);
        res_t r;
        int   n = 0;
        bit   seen = 0, got = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        op = v.op; size = v.size; sext = v.sext; base = v.base; offset = v.offset;
        wdata = v.wdata; dtr = v.dtr; start = 1;
        #1;
        chk({tag, ".accept"}, accept, 1);
        r.rd = v.erd; r.chkrd = v.chkrd; r.fc = v.efc;
        sbq.push_back(r);
        @(posedge clk);
        #1 start = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got  = 1;
                ackm = 0;
                if (sbq.size() == 0) begin
                    chk({tag, ".sb_empty"}, 1, 0);
                end else begin
                    r = sbq.pop_front();
                    chk({tag, ".fault"}, fault, (r.fc != 2'b00));
                    chk({tag, ".fcode"}, fcode, r.fc);
                    if (r.chkrd) chk({tag, ".rdata"}, rdata, r.rd);
                end
                chk({tag, ".reqm_at_done"}, reqm, 0);
            end else if (reqm) begin
                if (!seen) begin
                    seen = 1;
                    chk({tag, ".addr"}, addr, v.eaddr);
                    chk({tag, ".bmask"}, bmask, v.ebm);
                    chk({tag, ".rw"}, rw, (v.op == 2'b01));
                    if (v.op == 2'b01) chk({tag, ".dtw"}, dtw, v.edtw);
                end
                ackm = (v.ackdel >= 0 && n == v.ackdel);
                n++;
            end else begin
                ackm = 0;
            end
        end
        ackm = 0;
        if (!got) chk({tag, ".done_timeout"}, 0, 1);
        chk({tag, ".reqm_cycles"}, n, v.ereq);
    endtask

    initial begin
        int dcount;
        vt[0]  = mk(2'b00, 2'b10, 0, 32'h1000, 16'hFFFC, 0, 32'hDEADBEEF, 2,
                    32'h0FFC, 4'b1111, 0, 32'hDEADBEEF, 1, 2'b00, 3);
        vt[1]  = mk(2'b00, 2'b00, 1, 32'h2000, 16'h0003, 0, 32'h80123456, 0,
                    32'h2000, 4'b1000, 0, 32'hFFFFFF80, 1, 2'b00, 1);
        vt[2]  = mk(2'b00, 2'b00, 0, 32'h2000, 16'h0003, 0, 32'h80123456, 0,
                    32'h2000, 4'b1000, 0, 32'h00000080, 1, 2'b00, 1);
        vt[3]  = mk(2'b01, 2'b01, 0, 32'h3000, 16'h0002, 32'h0000ABCD, 0, 1,
                    32'h3000, 4'b1100, 32'hABCD0000, 0, 0, 2'b00, 2);
        vt[4]  = mk(2'b00, 2'b01, 0, 32'h3000, 16'h0001, 0, 0, 0,
                    0, 0, 0, 0, 0, 2'b01, 0);
        vt[5]  = mk(2'b00, 2'b10, 0, 32'h4000, 16'h0000, 0, 32'h11111111, -1,
                    32'h4000, 4'b1111, 0, 0, 0, 2'b10, 15);
        vt[6]  = mk(2'b00, 2'b10, 0, 32'h4000, 16'h0004, 0, 32'h12345678, 14,
                    32'h4004, 4'b1111, 0, 32'h12345678, 1, 2'b00, 15);
        vt[7]  = mk(2'b11, 2'b10, 0, 32'h4000, 16'h0000, 0, 0, 0,
                    0, 0, 0, 0, 0, 2'b11, 0);
        vt[8]  = mk(2'b00, 2'b11, 0, 32'h4000, 16'h0000, 0, 0, 0,
                    0, 0, 0, 0, 0, 2'b11, 0);
        vt[9]  = mk(2'b00, 2'b01, 1, 32'h5000, 16'h0002, 0, 32'h80017FFF, 0,
                    32'h5000, 4'b1100, 0, 32'hFFFF8001, 1, 2'b00, 1);
        vt[10] = mk(2'b00, 2'b01, 1, 32'h5000, 16'h0000, 0, 32'h80017FFF, 1,
                    32'h5000, 4'b0011, 0, 32'h00007FFF, 1, 2'b00, 2);
        vt[11] = mk(2'b01, 2'b00, 0, 32'h6000, 16'h0001, 32'h0000005A, 0, 0,
                    32'h6000, 4'b0010, 32'h00005A00, 0, 0, 2'b00, 1);
        vt[12] = mk(2'b00, 2'b10, 0, 32'hFFFFFFFC, 16'h0008, 0, 32'h0BADF00D, 0,
                    32'h0004, 4'b1111, 0, 32'h0BADF00D, 1, 2'b00, 1);
        vt[13] = mk(2'b00, 2'b10, 0, 32'h7000, 16'h0002, 0, 0, 0,
                    0, 0, 0, 0, 0, 2'b01, 0);
        vt[14] = mk(2'b11, 2'b00, 0, 32'h7001, 16'h0000, 0, 0, 0,
                    0, 0, 0, 0, 0, 2'b11, 0);

        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.fault", fault, 0);
        chk("rst.reqm", reqm, 0);
        chk("rst.rw", rw, 0);
        chk("rst.fcode", fcode, 0);
        chk("rst.addr", addr, 0);
        chk("rst.bmask", bmask, 0);
        chk("rst.dtw", dtw, 0);
        chk("rst.rdata", rdata, 0);

        for (int i = 0; i < 15; i++) run(i, vt[i]);

        // Interrupt wins over a simultaneous start; start is taken afterwards
        @(negedge clk);
        op = 2'b00; size = 2'b10; sext = 0; base = 32'h1000; offset = 0;
        start = 1; intrq = 1; addi = 32'h40; dtr = 32'hCAFEF00D;
        #1 chk("irq.accept", accept, 0);
        @(posedge clk);
        #1 intrq = 0;
        @(negedge clk);
        chk("irq.reqm", reqm, 1);
        chk("irq.addr", addr, 32'h140);
        chk("irq.bmask", bmask, 4'b1111);
        chk("irq.rw", rw, 0);
        chk("irq.accept_busy", accept, 0);
        ackm = 1;
        @(posedge clk);
        #1 ackm = 0;
        @(negedge clk);
        chk("irq.done", done, 1);
        chk("irq.rdata", rdata, 32'hCAFEF00D);
        chk("irq.fault", fault, 0);
        chk("irq.accept_fin", accept, 0);
        @(negedge clk);
        chk("irq.accept_after", accept, 1);
        start = 0;
        run(100, vt[0]);

        // Reset while a bus cycle is outstanding
        @(negedge clk);
        op = 2'b00; size = 2'b10; base = 32'h1000; offset = 0; start = 1;
        #1 chk("rstbus.accept", accept, 1);
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        chk("rstbus.reqm_before", reqm, 1);
        chk("rstbus.busy_before", busy, 1);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rstbus.reqm_after", reqm, 0);
        chk("rstbus.busy_after", busy, 0);
        dcount = (done === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("rstbus.no_done", dcount, 0);
        run(101, vt[0]);

        chk("sb.drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
